// File: rtl/motor_model_qep_gen.sv
// motor_model_qep_gen: emulates a quadrature encoder that tracks a motor-model rotor angle with rate-limited count steps.
module motor_model_qep_gen #(
  parameter int P_CNT_BITS = 12,
  parameter int P_MIN_GAP  = 8,
  parameter int P_MAX_LAG  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           i_Theta_one_turn_k,
  input  logic                  i_enable,
  input  logic                  i_clr_err,
  output logic                  o_QEP_A,
  output logic                  o_QEP_B,
  output logic                  o_QEP_I,
  output logic [P_CNT_BITS-1:0] o_count,
  output logic                  o_busy,
  output logic                  o_lag_err
);
  localparam int N = P_CNT_BITS;
  localparam logic [N-1:0] ONE = 1;
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
  logic [15:0] theta_q;
  logic [N-1:0] count, target, diff, diff_neg, mag, count_nxt;
  logic [7:0] gap;
  logic up, step, wrap, lag_set, unused_theta;
  assign target = theta_q[15 -: N];
  assign diff = target - count;
  assign diff_neg = -diff;
  // Half a turn is ambiguous in sign; resolve it as forward motion.
  assign up = !diff[N-1] || diff == HALF;
  assign mag = diff[N-1] ? diff_neg : diff;
  assign lag_set = 32'(mag) > P_MAX_LAG;
  assign step = i_enable && gap == 8'd0 && diff != '0;
  assign wrap = up ? &count : count == '0;
  assign count_nxt = step ? (up ? count + ONE : count - ONE) : count;
  assign o_busy = diff != '0;
  assign o_count = count;
  assign unused_theta = ^theta_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      theta_q   <= '0;
      count     <= '0;
      gap       <= '0;
      o_QEP_A   <= 1'b0;
      o_QEP_B   <= 1'b0;
      o_QEP_I   <= 1'b0;
      o_lag_err <= 1'b0;
    end else begin
      theta_q   <= i_Theta_one_turn_k;
      count     <= count_nxt;
      gap       <= step ? 8'(P_MIN_GAP - 1) : (gap != 8'd0 ? gap - 8'd1 : gap);
      o_QEP_A   <= count_nxt[0] ^ count_nxt[1];
      o_QEP_B   <= count_nxt[1];
      o_QEP_I   <= step && wrap;
      o_lag_err <= lag_set || (o_lag_err && !i_clr_err);
    end
  end
endmodule
